// File: rtl/sram_fifo.sv
// sram_fifo: first-word-fall-through FIFO over a 1-cycle synchronous-read memory with a 2-entry output stage
module sram_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH),
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q, s1;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] mem_cnt, count_next;
  logic [1:0] st_cnt, st_keep, st_next;
  logic rd_pend, push, pop, rd_en;
  assign push = push_valid_i & push_ready_o;
  assign pop = pop_valid_o & pop_ready_i;
  assign st_keep = st_cnt - {1'b0, pop};
  assign st_next = st_keep + {1'b0, rd_pend};
  assign rd_en = (mem_cnt != '0) && (st_next < 2'd2);
  assign count_next = count_o + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  // storage array: write on accepted push, registered read when the output stage has room
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data_i;
    if (rd_en) mem_q <= mem[rd_ptr];
  end
  // pointers, occupancy, flags and the two-slot output stage; clear mirrors reset but leaves push_ready high
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
      st_cnt <= 2'd0;
      s1 <= '0;
      pop_data_o <= '0;
      pop_valid_o <= 1'b0;
      count_o <= '0;
      empty_o <= 1'b1;
      full_o <= 1'b0;
      almost_full_o <= 1'b0;
      push_ready_o <= !rst;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(push);
      rd_ptr <= rd_ptr + ADDR_W'(rd_en);
      mem_cnt <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd_en);
      rd_pend <= rd_en;
      st_cnt <= st_next;
      pop_valid_o <= st_next != 2'd0;
      if (rd_pend && st_keep == 2'd0) pop_data_o <= mem_q;
      else if (pop && st_cnt == 2'd2) pop_data_o <= s1;
      if (rd_pend && st_keep == 2'd1) s1 <= mem_q;
      count_o <= count_next;
      empty_o <= count_next == '0;
      full_o <= count_next == (ADDR_W+1)'(DEPTH);
      almost_full_o <= count_next >= (ADDR_W+1)'(AFULL_THRESH);
      push_ready_o <= count_next != (ADDR_W+1)'(DEPTH);
    end
  end
endmodule
